// File: rtl/cga_pkg.sv
// Shared definitions for the compact GA sequencers: FSM state encoding and
// default widths/limits used as parameter defaults.
package cga_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DISPATCH = 2'd1,
    WAIT     = 2'd2,
    RESPOND  = 2'd3
  } cga_state_e;

  localparam int unsigned CGA_IND_W     = 32;
  localparam int unsigned CGA_FIT_W     = 16;
  localparam int unsigned CGA_MAX_EVALS = 100000;
  localparam int unsigned CGA_TIMEOUT   = 1024;
  localparam int unsigned CGA_CNT_W     = 32;

endpackage

// File: rtl/cga_timeout_counter.sv
// Cycle counter for evaluator timeouts. clear restarts from zero, en advances
// it, and expire flags the terminal count TimeoutCycles-1. The count holds at
// the terminal value; callers qualify expire with their own wait state.
// rst is asynchronous and active-low.
module cga_timeout_counter
  import cga_pkg::*;
#(
  parameter int unsigned TimeoutCycles = CGA_TIMEOUT
)(
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic expire
);

  localparam int unsigned CW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
  localparam logic [CW-1:0] LAST = CW'(TimeoutCycles - 1);

  logic [CW-1:0] cnt;

  // Advance while enabled, restart on clear, stop at the terminal count
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                     cnt <= '0;
    else if (clear)               cnt <= '0;
    else if (en && (cnt != LAST)) cnt <= cnt + 1'b1;
  end

  assign expire = (cnt == LAST);

endmodule

// File: rtl/cga_fitness_scheduler.sv
// Fitness evaluation sequencer for the compact GA core. Detects the core's
// test request, latches the candidate, runs a start/done handshake with the
// external evaluator (with timeout), returns fitness and counts evaluations.
// rst is asynchronous and active-low.
// Optional build macro CGA_BEST_TRACK_EN adds best_individual/best_fitness.
module cga_fitness_scheduler
  import cga_pkg::*;
#(
  parameter int unsigned IndividualWidth = CGA_IND_W,
  parameter int unsigned FitnessWidth    = CGA_FIT_W,
  parameter int unsigned MaxEvaluations  = CGA_MAX_EVALS,
  parameter int unsigned TimeoutCycles   = CGA_TIMEOUT,
  parameter int unsigned CountWidth      = CGA_CNT_W
)(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  input  logic [IndividualWidth-1:0] individual,
  input  logic                       test_individual,
  output logic                       fitness_end,
  output logic [FitnessWidth-1:0]    fitness,
  output logic                       eval_start,
  output logic [IndividualWidth-1:0] eval_individual,
  input  logic                       eval_done,
  input  logic [FitnessWidth-1:0]    eval_fitness,
  output logic [CountWidth-1:0]      eval_count,
  output logic                       run_done,
  output logic                       timeout_err
`ifdef CGA_BEST_TRACK_EN
  ,
  output logic [IndividualWidth-1:0] best_individual,
  output logic [FitnessWidth-1:0]    best_fitness
`endif
);

  cga_state_e state, state_nxt;

  logic                  ti_p0, ti_p1;
  logic                  req, pend, accept;
  logic                  cap_done, cap_to, respond;
  logic                  tmo_clear, tmo_en, tmo_expire;
  logic [CountWidth-1:0] count_inc;

  // Saturating increment: the evaluation counter sticks at all-ones
  function automatic logic [CountWidth-1:0] sat_inc(input logic [CountWidth-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign count_inc = sat_inc(eval_count);

  // Register the request strobe and keep a delayed copy for edge detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ti_p0 <= 1'b0;
      ti_p1 <= 1'b0;
    end else begin
      ti_p0 <= test_individual;
      ti_p1 <= ti_p0;
    end
  end

  assign req = ti_p0 & ~ti_p1;

  // One-deep pending request; an edge arriving while one is already pending is
  // dropped, but an edge coinciding with acceptance of the pending one is kept
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        pend <= 1'b0;
    else if (accept) pend <= pend & req;
    else if (req)    pend <= 1'b1;
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic and per-state strobes; eval_done outranks a same-cycle timeout
  always_comb begin
    state_nxt  = state;
    accept     = 1'b0;
    eval_start = 1'b0;
    tmo_clear  = 1'b0;
    tmo_en     = 1'b0;
    cap_done   = 1'b0;
    cap_to     = 1'b0;
    respond    = 1'b0;
    unique case (state)
      IDLE: begin
        if ((req || pend) && enable && !run_done) begin
          accept    = 1'b1;
          state_nxt = DISPATCH;
        end
      end
      DISPATCH: begin
        eval_start = 1'b1;
        tmo_clear  = 1'b1;
        state_nxt  = WAIT;
      end
      WAIT: begin
        tmo_en = 1'b1;
        if (eval_done) begin
          cap_done  = 1'b1;
          state_nxt = RESPOND;
        end else if (tmo_expire) begin
          cap_to    = 1'b1;
          state_nxt = RESPOND;
        end
      end
      RESPOND: begin
        respond   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  cga_timeout_counter #(
    .TimeoutCycles(TimeoutCycles)
  ) u_timeout (
    .clk   (clk),
    .rst   (rst),
    .clear (tmo_clear),
    .en    (tmo_en),
    .expire(tmo_expire)
  );

  // Latch the candidate on acceptance; capture the result or zero it on timeout
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      eval_individual <= '0;
      fitness         <= '0;
    end else begin
      if (accept)      eval_individual <= individual;
      if (cap_done)    fitness         <= eval_fitness;
      else if (cap_to) fitness         <= '0;
    end
  end

  // Completion flag, evaluation counter, run limit and sticky timeout status
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fitness_end <= 1'b0;
      eval_count  <= '0;
      run_done    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      if (accept)       fitness_end <= 1'b0;
      else if (respond) fitness_end <= 1'b1;
      if (respond) begin
        eval_count <= count_inc;
        if ((MaxEvaluations != 0) && (count_inc == CountWidth'(MaxEvaluations)))
          run_done <= 1'b1;
      end
      if (cap_to) timeout_err <= 1'b1;
    end
  end

`ifdef CGA_BEST_TRACK_EN
  logic timed_out;

  // Remember whether the evaluation in flight ended by timeout
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          timed_out <= 1'b0;
    else if (cap_done) timed_out <= 1'b0;
    else if (cap_to)   timed_out <= 1'b1;
  end

  // Keep the strictly-best completed candidate; timed-out results never count
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      best_individual <= '0;
      best_fitness    <= '0;
    end else if (respond && !timed_out && (fitness > best_fitness)) begin
      best_individual <= eval_individual;
      best_fitness    <= fitness;
    end
  end
`endif

endmodule

// File: tb/tb_cga_fitness_scheduler.sv
module tb_cga_fitness_scheduler;

  localparam int IW   = 32;
  localparam int FW   = 16;
  localparam int CW   = 32;
  localparam int MAXE = 6;
  localparam int TO   = 8;

  logic          clk, rst, enable, test_individual, eval_done;
  logic [IW-1:0] individual, eval_individual;
  logic [FW-1:0] eval_fitness, fitness;
  logic          fitness_end, eval_start, run_done, timeout_err;
  logic [CW-1:0] eval_count;
`ifdef CGA_BEST_TRACK_EN
  logic [IW-1:0] best_individual;
  logic [FW-1:0] best_fitness;
`endif

  cga_fitness_scheduler #(
    .IndividualWidth(IW), .FitnessWidth(FW), .MaxEvaluations(MAXE),
    .TimeoutCycles(TO), .CountWidth(CW)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .individual(individual),
    .test_individual(test_individual), .fitness_end(fitness_end),
    .fitness(fitness), .eval_start(eval_start), .eval_individual(eval_individual),
    .eval_done(eval_done), .eval_fitness(eval_fitness), .eval_count(eval_count),
    .run_done(run_done), .timeout_err(timeout_err)
`ifdef CGA_BEST_TRACK_EN
    , .best_individual(best_individual), .best_fitness(best_fitness)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Evaluator plan: what the bench-side evaluator answers for each dispatch
  typedef struct {
    logic [IW-1:0] ind;
    int            del;
    logic [FW-1:0] fit;
    bit            chk;
  } plan_t;

  // Expected response at each completion
  typedef struct {
    logic [FW-1:0] fit;
    logic [CW-1:0] cnt;
    bit            rd;
    bit            te;
    logic [IW-1:0] bi;
    logic [FW-1:0] bf;
  } exp_t;

  plan_t plan_q[$];
  exp_t  exp_q[$];

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int            m_count;
  bit            m_te;
  logic [IW-1:0] m_bi;
  logic [FW-1:0] m_bf;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic model_clear();
    m_count = 0;
    m_te    = 1'b0;
    m_bi    = '0;
    m_bf    = '0;
    plan_q.delete();
    exp_q.delete();
  endtask

  // Record one evaluation that the scheduler is expected to perform
  task automatic issue_model(input logic [IW-1:0] ind, input int del, input logic [FW-1:0] fit);
    plan_t p;
    exp_t  e;
    bit    to;
    to    = (del > TO);
    p.ind = ind; p.del = del; p.fit = fit; p.chk = 1'b1;
    plan_q.push_back(p);
    m_count++;
    if (to) m_te = 1'b1;
    else if (fit > m_bf) begin
      m_bf = fit;
      m_bi = ind;
    end
    e.fit = to ? '0 : fit;
    e.cnt = CW'(m_count);
    e.rd  = (m_count == MAXE);
    e.te  = m_te;
    e.bi  = m_bi;
    e.bf  = m_bf;
    exp_q.push_back(e);
  endtask

  // One-cycle request pulse; called just after a falling clock edge
  task automatic pulse(input logic [IW-1:0] ind);
    individual      = ind;
    test_individual = 1'b1;
    @(negedge clk);
    test_individual = 1'b0;
  endtask

  task automatic count_starts(input int n, output int c);
    c = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (eval_start === 1'b1) c++;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || plan_q.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_pending", 64'(exp_q.size() + plan_q.size()), 64'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_started();
    int n;
    n = 0;
    while (plan_q.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("start_seen", 64'(plan_q.size()), 64'd0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_fitness_end"}, 64'(fitness_end), 64'd0);
    check({tag, "_fitness"}, 64'(fitness), 64'd0);
    check({tag, "_eval_start"}, 64'(eval_start), 64'd0);
    check({tag, "_eval_individual"}, 64'(eval_individual), 64'd0);
    check({tag, "_eval_count"}, 64'(eval_count), 64'd0);
    check({tag, "_run_done"}, 64'(run_done), 64'd0);
    check({tag, "_timeout_err"}, 64'(timeout_err), 64'd0);
`ifdef CGA_BEST_TRACK_EN
    check({tag, "_best_fitness"}, 64'(best_fitness), 64'd0);
    check({tag, "_best_individual"}, 64'(best_individual), 64'd0);
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_zero("reset");
    @(negedge clk);
    rst = 1'b1;
    model_clear();
  endtask

  // Request from an idle scheduler, with request and completion latency checks
  task automatic run_timed(input logic [IW-1:0] ind, input int del, input logic [FW-1:0] fit,
                           input bit drop_en);
    int n;
    int m;
    wait_idle();
    issue_model(ind, del, fit);
    pulse(ind);
    n = 1;
    while (eval_start !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("req_to_start", 64'(n), 64'd2);
    if (drop_en) enable = 1'b0;
    m = 0;
    while (fitness_end !== 1'b1 && m < TO + 20) begin
      @(negedge clk);
      m++;
    end
    check("start_to_fitness_end", 64'(m), 64'((del <= TO) ? del + 2 : TO + 2));
    enable = 1'b1;
  endtask

  // Evaluator model: answers each dispatch according to the plan queue
  initial begin
    plan_t p;
    eval_done    = 1'b0;
    eval_fitness = '0;
    forever begin
      @(negedge clk);
      if (eval_start === 1'b1) begin
        if (plan_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_eval_start actual=1 required=0");
        end else begin
          p = plan_q.pop_front();
          check("eval_individual_at_start", 64'(eval_individual), 64'(p.ind));
          if (p.del <= TO) begin
            repeat (p.del) @(negedge clk);
            if (p.chk) check("eval_individual_stable", 64'(eval_individual), 64'(p.ind));
            eval_done    = 1'b1;
            eval_fitness = p.fit;
            @(negedge clk);
            eval_done    = 1'b0;
            eval_fitness = FW'($urandom);
          end
        end
      end
    end
  end

  // Monitor: compare each completion against the scoreboard
  initial begin
    exp_t e;
    bit   fe_prev;
    fe_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (fitness_end === 1'b1 && !fe_prev) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_fitness_end actual=1 required=0");
        end else begin
          e = exp_q.pop_front();
          check("fitness", 64'(fitness), 64'(e.fit));
          check("eval_count", 64'(eval_count), 64'(e.cnt));
          check("run_done", 64'(run_done), 64'(e.rd));
          check("timeout_err", 64'(timeout_err), 64'(e.te));
`ifdef CGA_BEST_TRACK_EN
          check("best_fitness", 64'(best_fitness), 64'(e.bf));
          check("best_individual", 64'(best_individual), 64'(e.bi));
`endif
        end
      end
      fe_prev = (fitness_end === 1'b1);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c;
    plan_t p;
    logic [IW-1:0] ind;
    logic [FW-1:0] fit;
    int del;

    rst             = 1'b1;
    enable          = 1'b0;
    test_individual = 1'b0;
    individual      = '0;
    model_clear();
    #2 rst = 1'b0;
    #1 check_zero("por");
    @(negedge clk);
    rst    = 1'b1;
    enable = 1'b1;
    repeat (2) @(negedge clk);

    // Basic evaluation, timeout, enable drop mid-evaluation
    run_timed(32'hDEADBEEF, 5, 16'h1234, 1'b0);
    run_timed(32'h0BADF00D, 99, 16'h7777, 1'b0);
    run_timed(32'h12345678, 4, 16'h0042, 1'b1);
    wait_idle();

    // Reset in the middle of WAIT; the evaluator answers late and must be ignored
    p.ind = 32'hCAFEF00D; p.del = 6; p.fit = 16'h5555; p.chk = 1'b0;
    plan_q.push_back(p);
    pulse(p.ind);
    wait_started();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1 check_zero("mid_wait_reset");
    @(negedge clk);
    rst = 1'b1;
    model_clear();
    count_starts(15, c);
    check("starts_after_reset", 64'(c), 64'd0);
    check("fitness_end_after_late_done", 64'(fitness_end), 64'd0);
    check("eval_count_after_late_done", 64'(eval_count), 64'd0);

    // Request while disabled stays pending; a second edge is ignored
    enable = 1'b0;
    issue_model(32'hA5A5A5A5, 3, 16'h0101);
    pulse(32'hA5A5A5A5);
    repeat (3) @(negedge clk);
    pulse(32'hA5A5A5A5);
    count_starts(8, c);
    check("starts_while_disabled", 64'(c), 64'd0);
    enable = 1'b1;
    count_starts(40, c);
    check("starts_after_enable", 64'(c), 64'd1);
    wait_idle();

    // Best-tracking sequence
    run_timed(32'h11111111, 3, 16'h0010, 1'b0);
    run_timed(32'h22222222, 4, 16'h0040, 1'b0);
    run_timed(32'h33333333, 2, 16'h0020, 1'b0);
    wait_idle();

    // Randomized runs up to the evaluation limit, then a blocked request
    for (int r = 0; r < 3; r++) begin
      do_reset();
      for (int k = 0; k < MAXE; k++) begin
        ind = $urandom;
        fit = FW'($urandom);
        del = int'($urandom_range(1, TO + 2));
        if ($urandom_range(0, 2) == 0) begin
          issue_model(ind, del, fit);
          pulse(ind);
          wait_started();
        end else begin
          run_timed(ind, del, fit, $urandom_range(0, 3) == 0);
        end
      end
      wait_idle();
      pulse($urandom);
      count_starts(30, c);
      check("starts_after_limit", 64'(c), 64'd0);
      check("eval_count_at_limit", 64'(eval_count), 64'(MAXE));
      check("run_done_at_limit", 64'(run_done), 64'd1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cga_fitness_scheduler.md
Name: cga_fitness_scheduler

Overview:
Sequences fitness evaluation for the compact GA core. Detects the core's test request and latches the candidate individual. Dispatches the candidate to an external fitness evaluator with a start/done handshake, with timeout protection. Returns the fitness and completion flag to the core, and counts evaluations up to a run limit.

Parameters:
IndividualWidth, 32, width of candidate individual
FitnessWidth, 16, width of fitness value
MaxEvaluations, 100000, evaluations before run_done asserts; 0 means unlimited
TimeoutCycles, 1024, evaluator cycles allowed before forced completion
CountWidth, 32, width of evaluation counter

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous active-low reset
enable  in  1  run enable; 0 blocks new dispatches
individual  in  IndividualWidth  candidate from GA core
test_individual  in  1  GA core request; a rising edge starts one evaluation
fitness_end  out  1  to GA core: fitness valid / evaluation complete
fitness  out  FitnessWidth  to GA core: fitness of last candidate
eval_start  out  1  one-cycle start pulse to evaluator
eval_individual  out  IndividualWidth  latched candidate, stable from start to done
eval_done  in  1  evaluator completion, one-cycle pulse
eval_fitness  in  FitnessWidth  evaluator result, valid with eval_done
eval_count  out  CountWidth  completed evaluations
run_done  out  1  sticky; evaluation limit reached
timeout_err  out  1  sticky; at least one evaluation timed out

Behaviour:
- Reset (rst=0, asynchronous) forces:
  - all outputs to 0;
  - FSM to IDLE;
  - edge-detect register to 0;
  - timeout counter to 0.
- Request detection: test_individual is registered; req = test_individual & ~prev. This gives one cycle of detection latency.
- IDLE:
  - On req with enable=1 and run_done=0: latch individual into eval_individual, clear fitness_end, go to DISPATCH.
  - On req while blocked: hold the request pending and service it once enable=1. Only one request is pending at a time; further edges are ignored.
- DISPATCH: assert eval_start for exactly one cycle, clear the timeout counter, go to WAIT.
- WAIT:
  - Timeout counter increments each cycle.
  - On eval_done: latch eval_fitness into fitness, go to RESPOND.
  - If the counter reaches TimeoutCycles-1 without eval_done: set fitness=0, set timeout_err, go to RESPOND.
  - eval_done and timeout in the same cycle: eval_done wins and timeout_err is not set.
- RESPOND:
  - Set fitness_end=1 and increment eval_count.
  - If MaxEvaluations!=0 and the new count equals MaxEvaluations, set run_done.
  - Go to IDLE.
- fitness_end stays high until the next accepted request; it clears in the same cycle the candidate is latched.
- eval_done in any state other than WAIT is ignored.
- eval_count saturates at all-ones; it does not wrap.
- A new req arriving during DISPATCH/WAIT/RESPOND is not latched immediately. It is held pending and accepted in the IDLE cycle that follows.
- enable deassert mid-evaluation does not abort; the current evaluation completes.
- Latency, req to eval_start: 2 cycles (IDLE latch, DISPATCH).
- Latency, eval_done to fitness_end: 2 cycles (WAIT capture, RESPOND).

Optional Feature:
CGA_BEST_TRACK_EN:
- Defined: adds outputs best_individual (IndividualWidth) and best_fitness (FitnessWidth), both reset to 0.
  - Updated in RESPOND when the new fitness > best_fitness (strictly greater, unsigned).
  - Timed-out evaluations never update them.
- Undefined: these ports and registers are absent.

Decomposition:
- Shared package cga_pkg holds:
  - FSM state encoding: IDLE=0, DISPATCH=1, WAIT=2, RESPOND=3;
  - default width constants.
- One natural sub-module: cga_timeout_counter (clear, enable, expire at TimeoutCycles-1), reusable by other GA sequencers.

Test Plan:
- Reset mid-WAIT (rst=0 for 1 cycle) -> all outputs 0, FSM IDLE, a late eval_done is ignored, no eval_start until the next edge.
- test_individual rising with individual=32'hDEADBEEF, eval_done 5 cycles after eval_start with eval_fitness=16'h1234 -> eval_start 2 cycles after the edge, eval_individual=DEADBEEF, fitness=1234, fitness_end high 2 cycles after eval_done, eval_count=1.
- Evaluator never responds, TimeoutCycles=8 -> fitness_end 8 cycles after eval_start plus RESPOND, fitness=0, timeout_err=1 and stays set.
- MaxEvaluations=3, four requests -> run_done after the third; the fourth request produces no eval_start; eval_count=3.
- enable=0 during a request edge, enable=1 ten cycles later -> a single eval_start after enable rises; a second edge while pending is ignored.
- CGA_BEST_TRACK_EN defined, fitness sequence 0x10, 0x40, 0x20 -> best_fitness=0x40 and best_individual=second candidate.
